// File: rtl/readout_sequencer.sv
// ---------------------------------------------------------------------------
// readout_sequencer
//
// Per-trigger event builder for a front-end readout block. On a trigger it
// pulses START to begin a scan, waits for the scan to finish (BUSY low),
// then streams one event:
//   header  {8'hEB, EVTNUM[14:0], N[8:0]}
//   N hits  {8'h00, HDATA}, fetched by stepping HADDR 0..N-1
//   trailer {8'hEE, EVTNUM[14:0], 8'h00, TO}
// N is the readout hit count clamped to 256. Triggers that arrive while an
// event is in flight are dropped and reported on TRIG_LOST.
//
// Parameters
//   RD_LAT   clk cycles from an HADDR update to valid HDATA (1..7)
//   TIMEOUT  clk cycles BUSY may stay high before the scan is aborted
//            (1..65535, only used with the option below)
//
// Build option
//   READOUT_SEQ_TIMEOUT_EN  when defined, a stuck BUSY aborts the scan after
//                           TIMEOUT cycles and emits an empty event with
//                           TO=1; when undefined, the sequencer waits on BUSY
//                           indefinitely and TO is always 0.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   TRIG       event trigger, sampled each rising edge
//   START      one-cycle scan start to readout
//   BUSY       readout scan in progress
//   SEL        host select to readout (held for the whole event)
//   HADDR      hit index to readout
//   HDATA      hit word {slot[7:0], adc[15:0]}
//   HNHIT      hit count from readout
//   OUT_DATA   event stream word
//   OUT_VALID  OUT_DATA valid
//   OUT_READY  downstream accepts word
//   TRIG_LOST  one-cycle pulse, trigger ignored
// ---------------------------------------------------------------------------
module readout_sequencer #(
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        TRIG,
  output logic        START,
  input  logic        BUSY,
  output logic        SEL,
  output logic [7:0]  HADDR,
  input  logic [23:0] HDATA,
  input  logic [8:0]  HNHIT,
  output logic [31:0] OUT_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic        TRIG_LOST
);

  typedef enum logic [2:0] {IDLE, ARM, WAIT, HDR, SETTLE, SEND, TRL} state_t;

  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [8:0]  n_hits;     // hits in this event, 0..256
  logic [8:0]  idx;        // 9 bits so that N=256 never needs a wrap
  logic [2:0]  lat_cnt;    // cycles spent in SETTLE since the HADDR update
  logic [23:0] hit_word;
  logic [14:0] evtnum;
  logic        sel_q;
  logic        trig_lost_q;
  logic        last_hit;
  logic        timeout_hit;
  logic        to_flag;
  logic [8:0]  n_clamp;

  // Counts of 256 and above all read out as a full 256-hit event.
  assign n_clamp  = HNHIT[8] ? 9'd256 : HNHIT;
  assign last_hit = (idx == n_hits - 9'd1);

  assign SEL       = sel_q;
  assign HADDR     = idx[7:0];
  assign TRIG_LOST = trig_lost_q;

`ifdef READOUT_SEQ_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [15:0] to_cnt;
  logic        to_q;

  // Counter only runs while waiting on a busy scan and restarts every event.
  assign timeout_hit = (state == WAIT) && BUSY && (to_cnt == TO_LAST);
  assign to_flag     = to_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      to_q   <= 1'b0;
    end else if (state == WAIT) begin
      if (!BUSY) begin
        to_cnt <= '0;
        to_q   <= 1'b0;
      end else if (timeout_hit) begin
        to_cnt <= '0;
        to_q   <= 1'b1;
      end else begin
        to_cnt <= to_cnt + 16'd1;
      end
    end else begin
      to_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign to_flag     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // START, OUT_VALID and OUT_DATA decode straight from the state so a reset
  // clears them in the same cycle, and the stream word cannot change while a
  // stalled word waits for OUT_READY.
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path through the
    // case that skipped an assignment would otherwise infer a latch.
    state_nxt = state;
    START     = 1'b0;
    OUT_VALID = 1'b0;
    OUT_DATA  = '0;
    case (state)
      IDLE:   if (TRIG) state_nxt = ARM;
      ARM: begin
        START     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:   if (!BUSY || timeout_hit) state_nxt = HDR;
      HDR: begin
        OUT_VALID = 1'b1;
        OUT_DATA  = {8'hEB, evtnum, n_hits};
        if (OUT_READY) state_nxt = (n_hits == 9'd0) ? TRL : SETTLE;
      end
      SETTLE: if (lat_cnt == LAT_LAST) state_nxt = SEND;
      SEND: begin
        OUT_VALID = 1'b1;
        OUT_DATA  = {8'h00, hit_word};
        if (OUT_READY) state_nxt = last_hit ? TRL : SETTLE;
      end
      TRL: begin
        OUT_VALID = 1'b1;
        OUT_DATA  = {8'hEE, evtnum, 8'h00, 7'd0, to_flag};
        if (OUT_READY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= 1'b0;
      n_hits      <= '0;
      idx         <= '0;
      lat_cnt     <= '0;
      hit_word    <= '0;
      evtnum      <= '0;
      trig_lost_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the values from before this edge, whatever the statement order.
      trig_lost_q <= TRIG && (state != IDLE);
      case (state)
        WAIT: begin
          if (!BUSY) begin
            n_hits <= n_clamp;
            sel_q  <= 1'b1;
          end else if (timeout_hit) begin
            n_hits <= '0;
            sel_q  <= 1'b1;
          end
        end
        HDR: begin
          // idx is already 0 here; entering SETTLE is the HADDR update.
          if (OUT_READY) lat_cnt <= '0;
        end
        SETTLE: begin
          if (lat_cnt == LAT_LAST) hit_word <= HDATA;
          else                     lat_cnt  <= lat_cnt + 3'd1;
        end
        SEND: begin
          if (OUT_READY && !last_hit) begin
            idx     <= idx + 9'd1;
            lat_cnt <= '0;
          end
        end
        TRL: begin
          if (OUT_READY) begin
            sel_q  <= 1'b0;
            idx    <= '0;
            evtnum <= evtnum + 15'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_readout_sequencer.sv
// ---------------------------------------------------------------------------
// tb_readout_sequencer
//
// Directed bench for readout_sequencer. The readout side is modelled as a
// zero-latency lookup HDATA = 24'h0100C8 + HADDR, and BUSY is driven by the
// bench around each START. Expected event words are built from the event
// format and a bench-side event counter.
// ---------------------------------------------------------------------------
module tb_readout_sequencer;

  localparam int RD_LAT  = 1;
  localparam int TIMEOUT = 16;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        TRIG      = 1'b0;
  logic        START;
  logic        BUSY      = 1'b0;
  logic        SEL;
  logic [7:0]  HADDR;
  logic [23:0] HDATA;
  logic [8:0]  HNHIT     = '0;
  logic [31:0] OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic        TRIG_LOST;

  int          checks = 0;
  int          errors = 0;
  logic [14:0] evt_model = '0;

  always #5 clk = ~clk;

  assign HDATA = 24'h0100C8 + {16'h0000, HADDR};

  readout_sequencer #(
    .RD_LAT  (RD_LAT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .TRIG      (TRIG),
    .START     (START),
    .BUSY      (BUSY),
    .SEL       (SEL),
    .HADDR     (HADDR),
    .HDATA     (HDATA),
    .HNHIT     (HNHIT),
    .OUT_DATA  (OUT_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .TRIG_LOST (TRIG_LOST)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // One full event: trigger, scan, then collect the stream and compare.
  task automatic run_event(input int nhit, input bit toggle, input bit inject, input bit stuck);
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [31:0] held;
    int          n;
    int          nidx;
    int          first_valid;
    int          lost_phase;
    int          guard;
    bit          done;
    bit          injected;
    bit          stalled;

    n = (nhit > 256) ? 256 : nhit;
    if (stuck) n = 0;
    exp_q.push_back({8'hEB, evt_model, 9'(n)});
    for (int i = 0; i < n; i++) exp_q.push_back({8'h00, 24'h0100C8 + 24'(i)});
    exp_q.push_back({8'hEE, evt_model, 8'h00, 7'd0, stuck});

    @(negedge clk);
    TRIG  = 1'b1;
    HNHIT = 9'(nhit);
    BUSY  = 1'b1;
    @(negedge clk);
    TRIG = 1'b0;
    check("start_pulse", 32'(START), 32'd1);
    @(negedge clk);
    check("start_low", 32'(START), 32'd0);
    nidx = 1;
    if (!stuck) begin
      repeat (2) @(negedge clk);
      nidx += 2;
      check("wait_hold", 32'(OUT_VALID), 32'd0);
      BUSY = 1'b0;
    end

    first_valid = -1;
    lost_phase  = 0;
    injected    = 1'b0;
    stalled     = 1'b0;
    done        = 1'b0;
    guard       = 0;
    held        = '0;
    OUT_READY   = 1'b1;
    while (!done && guard < 2000) begin
      @(negedge clk);
      nidx++;
      guard++;
      if (lost_phase == 1) begin
        TRIG = 1'b0;
        check("trig_lost_pulse", 32'(TRIG_LOST), 32'd1);
        lost_phase = 2;
      end else if (lost_phase == 2) begin
        check("trig_lost_clear", 32'(TRIG_LOST), 32'd0);
        lost_phase = 3;
      end
      if (n == 0) check("haddr_zero", 32'(HADDR), 32'd0);
      if (stalled) begin
        check("stall_valid", 32'(OUT_VALID), 32'd1);
        check("stall_hold", OUT_DATA, held);
      end
      if (OUT_VALID && first_valid < 0) begin
        first_valid = nidx;
        check("sel_in_stream", 32'(SEL), 32'd1);
      end
      if (inject && !injected && OUT_VALID && got_q.size() == 1) begin
        TRIG       = 1'b1;
        injected   = 1'b1;
        lost_phase = 1;
      end
      OUT_READY = toggle ? ~OUT_READY : 1'b1;
      stalled   = OUT_VALID && !OUT_READY;
      held      = OUT_DATA;
      if (OUT_VALID && OUT_READY) begin
        got_q.push_back(OUT_DATA);
        if (got_q.size() == exp_q.size()) done = 1'b1;
      end
    end

    check("stream_end", 32'(done), 32'd1);
    check("word_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("word%0d", i), got_q[i], exp_q[i]);
    if (inject) check("trig_lost_seen", 32'(lost_phase), 32'd3);
    if (stuck)  check("abort_latency", 32'(first_valid), 32'd17);

    @(negedge clk);
    check("sel_after", 32'(SEL), 32'd0);
    check("valid_after", 32'(OUT_VALID), 32'd0);
    check("haddr_after", 32'(HADDR), 32'd0);
    OUT_READY = 1'b1;
    BUSY      = 1'b0;
    evt_model = evt_model + 15'd1;
  endtask

  // Start a 3-hit event and pull reset while the second hit word is shown.
  task automatic reset_mid_send();
    bit found;
    found = 1'b0;
    @(negedge clk);
    TRIG  = 1'b1;
    HNHIT = 9'd3;
    BUSY  = 1'b1;
    @(negedge clk);
    TRIG = 1'b0;
    @(negedge clk);
    BUSY      = 1'b0;
    OUT_READY = 1'b1;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (OUT_VALID && OUT_DATA == 32'h000100C9) found = 1'b1;
    end
    check("send_reached", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_start", 32'(START), 32'd0);
    check("rst_sel", 32'(SEL), 32'd0);
    check("rst_haddr", 32'(HADDR), 32'd0);
    check("rst_data", OUT_DATA, 32'd0);
    check("rst_valid", 32'(OUT_VALID), 32'd0);
    check("rst_lost", 32'(TRIG_LOST), 32'd0);
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    evt_model = '0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_start", 32'(START), 32'd0);
    check("reset_sel", 32'(SEL), 32'd0);
    check("reset_haddr", 32'(HADDR), 32'd0);
    check("reset_data", OUT_DATA, 32'd0);
    check("reset_valid", 32'(OUT_VALID), 32'd0);
    check("reset_lost", 32'(TRIG_LOST), 32'd0);
    rst_n = 1'b1;

    run_event(3, 1'b0, 1'b0, 1'b0);    // EB000003, 000100C8..CA, EE000000
    run_event(0, 1'b0, 1'b0, 1'b0);    // header and trailer only
    run_event(300, 1'b0, 1'b0, 1'b0);  // clamps to 256 hits
    run_event(2, 1'b1, 1'b0, 1'b0);    // READY toggling every cycle
    run_event(3, 1'b0, 1'b1, 1'b0);    // trigger dropped during SEND
    reset_mid_send();
`ifdef READOUT_SEQ_TIMEOUT_EN
    run_event(5, 1'b0, 1'b0, 1'b1);    // BUSY stuck: EB000000, EE000001
`endif
    run_event(1, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
